asymmetric_dist_ram: RTL and testbench
======================================

Name: asymmetric_dist_ram

Overview:
- Simple dual-port distributed (LUT) RAM with a wide write port and a narrow, asynchronous read port.
- Each write stores one WIDTH_IN word; reads return one WIDTH_OUT sub-word selected by a finer-grained address.
- Serves as the storage array of the width-down-converting FIFO: the write address is the FIFO head, the read address is the FIFO tail.

Parameters:
- WIDTH_IN, 64: write data width in bits.
- WIDTH_OUT, 8: read data width in bits. WIDTH_IN must be WIDTH_IN/WIDTH_OUT = power-of-two multiple of WIDTH_OUT.
- DEPTH_IN, 32: number of wide words. Must be a power of two.
- RATIO, WIDTH_IN/WIDTH_OUT (derived, localparam): sub-words per wide word.
- LOG2_RATIO, log2(RATIO) (derived, localparam).
- DEPTH_OUT, DEPTH_IN*RATIO: number of narrow entries.
- DEPTH_IN_ADDR_WIDTH, log2(DEPTH_IN-1) = 5: write address width.
- DEPTH_OUT_ADDR_WIDTH, log2(DEPTH_OUT-1) = 8: read address width.

Ports:
- clk, input, 1: single clock; all writes occur on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- we, input, 1: write enable.
- waddr, input, DEPTH_IN_ADDR_WIDTH: wide-word write address.
- d, input, WIDTH_IN: write data.
- raddr, input, DEPTH_OUT_ADDR_WIDTH: narrow-entry read address.
- q, output, WIDTH_OUT: read data.

Behaviour:
- Storage is DEPTH_IN x WIDTH_IN, organised as RATIO lanes of DEPTH_IN x WIDTH_OUT.
- Write is synchronous:
  - At a rising clk edge with we=1 and rst=0, mem[waddr] <= d.
  - Lane k of the word receives d[k*WIDTH_OUT +: WIDTH_OUT].
- Read is asynchronous (combinational, zero latency):
  - word = raddr[DEPTH_OUT_ADDR_WIDTH-1:LOG2_RATIO].
  - lane = raddr[LOG2_RATIO-1:0].
  - q = mem[word][lane*WIDTH_OUT +: WIDTH_OUT].
  - Lane 0 is the least-significant slice, so sequential reads return d little-end first.
- Read-during-write to the same word: q shows the old data until the clk edge, then the new data immediately after the edge, with no extra cycle.
- Reset:
  - rst=1 blocks writes in that cycle, even if we=1.
  - rst does not clear contents; distributed RAM has no array reset.
  - q remains a combinational function of raddr and contents during reset.
- Initial contents are all zero at configuration and simulation start. With no write since power-up, q=0.
- Addresses are used modulo their widths. No out-of-range handling is needed because depths are powers of two.
- The block has no full/empty tracking and no overflow checks; pointer management belongs to the parent FIFO.
- The array must infer LUT RAM: no output register, no read enable.

Decomposition:
- Shared package:
  - constant function log2(x), returning the number of bits needed to represent x;
  - derivation of RATIO, LOG2_RATIO and the address widths, so the FIFO and the RAM agree.
- One natural sub-module: dist_ram_lane, a DEPTH_IN x WIDTH_OUT single-write, async-read LUT RAM.
  - Instantiate it RATIO times via generate, one per lane, sharing we and waddr.
  - Read side: a RATIO:1 mux on raddr[LOG2_RATIO-1:0] selects the lane output.

Test Plan:
- Basic write/read: write d=64'h0807060504030201 at waddr=0; read raddr=0..7 -> q=01,02,...,08, each valid in the same cycle the address is applied.
- Top-address wrap: write d=64'hF8F7F6F5F4F3F2F1 at waddr=31; raddr=248..255 -> q=F1..F8; raddr=0 still returns 01.
- Read-during-write: hold raddr=3 on word 0, then write word 0 with 64'hAAAA_AAAA_AAAA_AAAA -> q=04 before the edge, AA immediately after.
- Write gating: with we=0, present d=all-ones at waddr=0 for several edges -> word 0 unchanged (raddr=0 -> 01). Repeat with we=1, rst=1 -> still unchanged.
- Reset preserves contents: pulse rst for 3 cycles after writes -> all previously written sub-words read back unchanged; an unwritten word (waddr=5, raddr=40..47) reads 00.
- Parameter sweep: WIDTH_IN=32, WIDTH_OUT=16, DEPTH_IN=16; write 32'h1234ABCD at waddr=2 -> raddr=4 gives ABCD, raddr=5 gives 1234.

Source files
------------

// File: rtl/asymmetric_dist_ram_pkg.sv
// Shared constants and helpers so the width-down FIFO and its RAM agree
// on ratio and address widths.
package asymmetric_dist_ram_pkg;

    localparam int DEF_WIDTH_IN  = 64;
    localparam int DEF_WIDTH_OUT = 8;
    localparam int DEF_DEPTH_IN  = 32;

    // Number of bits needed to represent x (log2(31) = 5, log2(255) = 8).
    function automatic int log2(input int x);
        int r;
        r = 0;
        for (int v = x; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int ratio_of(input int width_in, input int width_out);
        return width_in / width_out;
    endfunction

    // Lane-select bits. RATIO is a power of two of at least 2.
    function automatic int log2_ratio_of(input int width_in, input int width_out);
        return log2(ratio_of(width_in, width_out) - 1);
    endfunction

    function automatic int in_addr_width(input int depth_in);
        return log2(depth_in - 1);
    endfunction

    function automatic int out_addr_width(input int width_in, input int width_out,
                                          input int depth_in);
        return log2(depth_in * ratio_of(width_in, width_out) - 1);
    endfunction

endpackage

// File: rtl/asymmetric_dist_ram_if.sv
// Bus between the FIFO pointer logic (master) and the storage array (slave).
// There is no valid/ready handshake: a write is qualified only by we at the
// rising clk edge, and q is always valid as a combinational function of raddr
// and the array contents.
interface asymmetric_dist_ram_if
    import asymmetric_dist_ram_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int DEPTH_IN  = DEF_DEPTH_IN
);
    localparam int DEPTH_IN_ADDR_WIDTH  = in_addr_width(DEPTH_IN);
    localparam int DEPTH_OUT_ADDR_WIDTH = out_addr_width(WIDTH_IN, WIDTH_OUT, DEPTH_IN);

    logic                            we;
    logic [DEPTH_IN_ADDR_WIDTH-1:0]  waddr;
    logic [WIDTH_IN-1:0]             d;
    logic [DEPTH_OUT_ADDR_WIDTH-1:0] raddr;
    logic [WIDTH_OUT-1:0]            q;

    modport master (output we, output waddr, output d, output raddr, input q);
    modport slave  (input we, input waddr, input d, input raddr, output q);

endinterface

// File: rtl/asymmetric_dist_ram_lane.sv
// One lane of the asymmetric RAM: DEPTH x WIDTH, synchronous write,
// asynchronous read, no output register so it maps onto LUT RAM.
// Contents start at zero from configuration; there is no array reset.
module dist_ram_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: reset only blocks the write, it never clears the array.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem[waddr] <= d;
        end
    end

    // Read port: zero latency, so new data is visible right after the edge.
    always_comb begin
        q = mem[raddr];
    end

endmodule

// File: rtl/asymmetric_dist_ram.sv
// Wide-write / narrow-read distributed RAM used as the storage of the
// width-down FIFO. Built from RATIO lanes; lane 0 holds the least-significant
// slice so sequential narrow reads return each word little-end first.
module asymmetric_dist_ram
    import asymmetric_dist_ram_pkg::*;
#(
    parameter int WIDTH_IN  = DEF_WIDTH_IN,
    parameter int WIDTH_OUT = DEF_WIDTH_OUT,
    parameter int DEPTH_IN  = DEF_DEPTH_IN
) (
    input logic                  clk,
    input logic                  rst,
    asymmetric_dist_ram_if.slave bus
);

    localparam int RATIO                = ratio_of(WIDTH_IN, WIDTH_OUT);
    localparam int LOG2_RATIO           = log2_ratio_of(WIDTH_IN, WIDTH_OUT);
    localparam int DEPTH_OUT            = DEPTH_IN * RATIO;
    localparam int DEPTH_IN_ADDR_WIDTH  = in_addr_width(DEPTH_IN);
    localparam int DEPTH_OUT_ADDR_WIDTH = out_addr_width(WIDTH_IN, WIDTH_OUT, DEPTH_IN);

    logic [DEPTH_IN_ADDR_WIDTH-1:0] rword;
    logic [LOG2_RATIO-1:0]          rlane;
    logic [WIDTH_OUT-1:0]           lane_q [RATIO];

    assign rword = bus.raddr[DEPTH_OUT_ADDR_WIDTH-1:LOG2_RATIO];
    assign rlane = bus.raddr[LOG2_RATIO-1:0];

    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        dist_ram_lane #(
            .WIDTH (WIDTH_OUT),
            .DEPTH (DEPTH_IN),
            .AW    (DEPTH_IN_ADDR_WIDTH)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .we    (bus.we),
            .waddr (bus.waddr),
            .d     (bus.d[k*WIDTH_OUT +: WIDTH_OUT]),
            .raddr (rword),
            .q     (lane_q[k])
        );
    end

    // RATIO:1 mux picks the addressed sub-word from the lane outputs.
    always_comb begin
        bus.q = lane_q[rlane];
    end

endmodule

// File: tb/tb_asymmetric_dist_ram.sv
// Directed bench for asymmetric_dist_ram: default 64->8 x32 instance plus a
// 32->16 x16 instance. Drivers push expected values; a negedge monitor pops
// and compares.
module tb_asymmetric_dist_ram;

    logic clk;
    logic rst;

    asymmetric_dist_ram_if #(.WIDTH_IN(64), .WIDTH_OUT(8),  .DEPTH_IN(32)) bus  ();
    asymmetric_dist_ram_if #(.WIDTH_IN(32), .WIDTH_OUT(16), .DEPTH_IN(16)) bus2 ();

    asymmetric_dist_ram #(.WIDTH_IN(64), .WIDTH_OUT(8), .DEPTH_IN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    asymmetric_dist_ram #(.WIDTH_IN(32), .WIDTH_OUT(16), .DEPTH_IN(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach end of test");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [7:0]  exp_q[$];
    string       name_q[$];
    logic [15:0] exp2_q[$];
    string       name2_q[$];
    logic        pend1 = 1'b0;
    logic        pend2 = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;

    always @(negedge clk) begin
        if (pend1) begin
            logic [7:0] e;
            string      nm;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb1_underflow: got q=%h with no expected value", bus.q);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus.q === e) pass_cnt++;
                else $display("FAIL %s: got %h expected %h", nm, bus.q, e);
            end
        end
        if (pend2) begin
            logic [15:0] e2;
            string       nm2;
            chk_cnt++;
            if (exp2_q.size() == 0) begin
                $display("FAIL sb2_underflow: got q=%h with no expected value", bus2.q);
            end else begin
                e2  = exp2_q.pop_front();
                nm2 = name2_q.pop_front();
                if (bus2.q === e2) pass_cnt++;
                else $display("FAIL %s: got %h expected %h", nm2, bus2.q, e2);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; the monitor samples at the next negedge.
    task automatic expect1(input logic [7:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        pend1 = 1'b1;
        @(negedge clk);
        #1;
        pend1 = 1'b0;
    endtask

    task automatic expect2(input logic [15:0] e, input string nm);
        exp2_q.push_back(e);
        name2_q.push_back(nm);
        pend2 = 1'b1;
        @(negedge clk);
        #1;
        pend2 = 1'b0;
    endtask

    task automatic rd1(input logic [7:0] addr, input logic [7:0] e, input string nm);
        @(posedge clk);
        #1;
        bus.raddr = addr;
        expect1(e, nm);
    endtask

    task automatic rd2(input logic [4:0] addr, input logic [15:0] e, input string nm);
        @(posedge clk);
        #1;
        bus2.raddr = addr;
        expect2(e, nm);
    endtask

    task automatic wr1(input logic [4:0] addr, input logic [63:0] data);
        @(posedge clk);
        #1;
        bus.we    = 1'b1;
        bus.waddr = addr;
        bus.d     = data;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
    endtask

    task automatic wr2(input logic [3:0] addr, input logic [31:0] data);
        @(posedge clk);
        #1;
        bus2.we    = 1'b1;
        bus2.waddr = addr;
        bus2.d     = data;
        @(posedge clk);
        #1;
        bus2.we    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.d      = '0;
        bus.raddr  = '0;
        bus2.we    = 1'b0;
        bus2.waddr = '0;
        bus2.d     = '0;
        bus2.raddr = '0;

        // Power-up contents are zero, readable during reset.
        rd1(8'd0, 8'h00, "init_zero");
        rd2(5'd0, 16'h0000, "init_zero_w16");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic write/read, little-end first.
        wr1(5'd0, 64'h0807060504030201);
        for (int i = 0; i < 8; i++) begin
            rd1(8'(i), 8'(i + 1), $sformatf("w0_sub%0d", i));
        end

        // Top word and address wrap.
        wr1(5'd31, 64'hF8F7F6F5F4F3F2F1);
        for (int i = 0; i < 8; i++) begin
            rd1(8'(248 + i), 8'(8'hF1 + i), $sformatf("w31_sub%0d", i));
        end
        rd1(8'd0, 8'h01, "w0_after_w31");

        // Write gating: we=0.
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.waddr = 5'd0;
        bus.d     = '1;
        repeat (3) @(posedge clk);
        rd1(8'd0, 8'h01, "we0_blocks");

        // Write gating: we=1 with rst=1.
        @(posedge clk);
        #1;
        rst       = 1'b1;
        bus.we    = 1'b1;
        bus.waddr = 5'd0;
        bus.d     = '1;
        repeat (3) @(posedge clk);
        #1;
        bus.we = 1'b0;
        rst    = 1'b0;
        rd1(8'd0, 8'h01, "rst_blocks_sub0");
        rd1(8'd7, 8'h08, "rst_blocks_sub7");

        // Reset pulse preserves contents; unwritten word reads zero.
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd1(8'(i), 8'(i + 1), $sformatf("rst_keep_w0_sub%0d", i));
            rd1(8'(248 + i), 8'(8'hF1 + i), $sformatf("rst_keep_w31_sub%0d", i));
            rd1(8'(40 + i), 8'h00, $sformatf("unwritten_w5_sub%0d", i));
        end

        // Read-during-write on word 0, raddr held at 3.
        @(posedge clk);
        #1;
        bus.raddr = 8'd3;
        bus.waddr = 5'd0;
        bus.d     = 64'hAAAA_AAAA_AAAA_AAAA;
        bus.we    = 1'b1;
        expect1(8'h04, "rdw_before_edge");
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        expect1(8'hAA, "rdw_after_edge");
        rd1(8'd7, 8'hAA, "rdw_word0_sub7");
        rd1(8'd248, 8'hF1, "rdw_w31_untouched");

        // Narrower ratio instance: 32->16, depth 16.
        wr2(4'd2, 32'h1234ABCD);
        rd2(5'd4, 16'hABCD, "w16_sub_lo");
        rd2(5'd5, 16'h1234, "w16_sub_hi");
        rd2(5'd3, 16'h0000, "w16_neighbour");

        // Scoreboard drained.
        @(posedge clk);
        chk_cnt++;
        if (exp_q.size() == 0 && exp2_q.size() == 0) pass_cnt++;
        else $display("FAIL sb_drain: got %0d/%0d left expected 0/0", exp_q.size(), exp2_q.size());

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
